// File: rtl/nec_ir_receiver.sv
// NEC infrared frame decoder: measures pulse widths of the demodulated, active-low receiver
// output in microsecond ticks and assembles 32-bit frames with checksum validation.
module nec_ir_receiver #(
  parameter int unsigned TICK_DIV        = 50,
  parameter int unsigned LEAD_LOW_MIN    = 8000,
  parameter int unsigned LEAD_LOW_MAX    = 10000,
  parameter int unsigned LEAD_HIGH_MIN   = 4000,
  parameter int unsigned REPEAT_HIGH_MIN = 1800,
  parameter int unsigned BIT_LOW_MAX     = 1000,
  parameter int unsigned BIT_ONE_MIN     = 1200,
  parameter int unsigned BIT_HIGH_MAX    = 2500,
  parameter int unsigned TIMEOUT         = 20000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Signal,
  output logic [31:0] Data,
  output logic        Valid,
  output logic        Repeat,
  output logic        Err
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PrescW-1:0] PrescLast     = PrescW'(TICK_DIV - 1);
  localparam logic [15:0]       LeadLowMin    = 16'(LEAD_LOW_MIN);
  localparam logic [15:0]       LeadLowMax    = 16'(LEAD_LOW_MAX);
  localparam logic [15:0]       LeadHighMin   = 16'(LEAD_HIGH_MIN);
  localparam logic [15:0]       RepeatHighMin = 16'(REPEAT_HIGH_MIN);
  localparam logic [15:0]       BitLowMax     = 16'(BIT_LOW_MAX);
  localparam logic [15:0]       BitOneMin     = 16'(BIT_ONE_MIN);
  localparam logic [15:0]       BitHighMax    = 16'(BIT_HIGH_MAX);
  localparam logic [15:0]       TimeoutLimit  = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StLeadLow,
    StLeadHigh,
    StBitLow,
    StBitHigh
  } state_e;

  state_e state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic fall, rise;

  logic [PrescW-1:0] presc_q;
  logic [15:0]       dur_q;
  logic              tick;
  logic              clr;

  logic [31:0] sr_q, sr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        valid_d, repeat_d, err_d;
  logic        bit_val;
  logic [31:0] cand;

  // Synchronizer plus history; idle level is high so reset preloads ones.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= Signal;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign fall = s3_q & ~s2_q;
  assign rise = ~s3_q & s2_q;

  assign tick = (presc_q == PrescLast);

  always_ff @(posedge CLK) begin
    if (Reset || clr) begin
      presc_q <= '0;
      dur_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick && dur_q != 16'hFFFF) begin
        dur_q <= dur_q + 16'd1;
      end
    end
  end

  assign bit_val = (dur_q >= BitOneMin);
  assign cand    = {bit_val, sr_q[31:1]};

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    repeat_d = 1'b0;
    err_d    = 1'b0;
    clr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          clr     = 1'b1;
          state_d = StLeadLow;
        end
      end
      StLeadLow: begin
        if (rise) begin
          clr = 1'b1;
          if (dur_q >= LeadLowMin && dur_q <= LeadLowMax) begin
            state_d = StLeadHigh;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else if (dur_q > LeadLowMax) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StLeadHigh: begin
        if (fall) begin
          clr = 1'b1;
          if (dur_q >= LeadHighMin) begin
            cnt_d   = '0;
            state_d = StBitLow;
          end else if (dur_q >= RepeatHighMin) begin
            repeat_d = 1'b1;
            state_d  = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StBitLow: begin
        if (rise) begin
          clr = 1'b1;
          if (dur_q <= BitLowMax) begin
            state_d = StBitHigh;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StBitHigh: begin
        if (fall) begin
          clr   = 1'b1;
          sr_d  = cand;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            // Only the command byte pair is checked; address may be extended.
            if (cand[31:24] == ~cand[23:16]) begin
              data_d  = cand;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = StIdle;
          end else begin
            state_d = StBitLow;
          end
        end else if (dur_q > BitHighMax) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A qualifying edge in the same cycle takes precedence over the timeout.
    if (state_q != StIdle && !clr && dur_q > TimeoutLimit) begin
      err_d   = 1'b1;
      state_d = StIdle;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      Valid   <= 1'b0;
      Repeat  <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      Valid   <= valid_d;
      Repeat  <= repeat_d;
      Err     <= err_d;
    end
  end

  assign Data = data_q;

endmodule
